vend_sequencer: RTL and testbench
=================================

VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N_PROD, 4, number of product slots
- CREDIT_W, 4, credit register width
- MAX_CREDIT, 15, credit saturation value
- DISP_TIMEOUT, 32, cycles allowed for disp_ack
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- coin  in  1  one-cycle pulse, one credit unit inserted
- select  in  1  one-cycle pulse, vend request
- prod_id  in  2  product index, sampled with select
- cancel  in  1  one-cycle pulse, return all credit
- stock_empty  in  N_PROD  per-slot empty flag
- disp_ack  in  1  dispense mechanism done
- disp_req  out  1  dispense request, held until ack or timeout
- disp_id  out  2  product being dispensed, stable while disp_req=1
- change_pulse  out  1  one credit unit returned per high cycle
- credit  out  CREDIT_W  current credit
- sel_err  out  1  one-cycle pulse, select rejected
- coin_rej  out  1  one-cycle pulse, coin not accepted
- busy  out  1  state != IDLE
- fault  out  1  sticky dispense-timeout flag
REQ-003 All outputs SHALL be driven from registers or decoded only from the state register.

Function
REQ-004 FSM states SHALL be IDLE, DISPENSE, CHANGE.
REQ-005 IDLE, coin: credit+1, saturate at MAX_CREDIT; coin at MAX_CREDIT -> coin_rej next cycle, credit unchanged.
REQ-006 coin in DISPENSE or CHANGE SHALL be rejected: coin_rej next cycle, credit unchanged.
REQ-007 IDLE, select: stock_empty[prod_id]=1 or credit < PRICE[prod_id] -> sel_err next cycle, stay IDLE, credit unchanged.
REQ-008 IDLE, valid select at cycle N: credit -= PRICE[prod_id], disp_id <= prod_id, disp_req=1 and state DISPENSE from cycle N+1.
REQ-009 Simultaneous coin+select in IDLE: select checked against pre-coin credit; accepted coin SHALL still be added (credit - price + 1), whether or not select is accepted.
REQ-010 IDLE, cancel with credit>0 -> CHANGE; cancel with credit=0 ignored; cancel has priority over select in the same cycle, coin still counted.
REQ-011 DISPENSE: disp_ack at cycle M -> disp_req=0 at M+1; next state CHANGE if credit>0, else IDLE.
REQ-012 DISPENSE: no ack for DISP_TIMEOUT cycles -> disp_req=0, credit += PRICE[disp_id] (refund), fault=1, next state CHANGE.
REQ-013 disp_ack outside DISPENSE SHALL be ignored.
REQ-014 CHANGE: change_pulse=1 every cycle in CHANGE, credit-1 per cycle; credit=1 -> next state IDLE; exactly credit-on-entry pulses.
REQ-015 select and cancel outside IDLE SHALL be ignored with no sel_err.
REQ-016 Prices SHALL be PRICE = {3,5,7,9} for prod_id 0..3.

Reset
REQ-017 reset low SHALL asynchronously force state IDLE, credit=0, all outputs 0 including fault; credit lost on reset mid-operation.
REQ-018 First state change SHALL occur on the first rising clk edge after reset deasserts.

Structure
REQ-019 Package vend_pkg SHALL hold the state enum, N_PROD, CREDIT_W, MAX_CREDIT, DISP_TIMEOUT and the PRICE table.
REQ-020 Timeout counting SHALL be one sub-module vend_timeout_timer (clear, enable, expired), instantiated once.

Verification
REQ-021 Reset asserted mid-clock -> all outputs 0 immediately, state IDLE.
REQ-022 3 coins, select id0 -> credit 3 then 0, disp_req/disp_id=0 next cycle, ack after 4 cycles -> IDLE, 0 change_pulses.
REQ-023 7 coins, select id1, ack -> exactly 2 change_pulses, credit 0, busy low after.
REQ-024 2 coins, select id1 -> sel_err, credit 2; cancel -> 2 change_pulses; 16 coins -> credit 15, coin_rej on 16th.
REQ-025 9 coins, select id3, no ack -> disp_req drops after 32 cycles, fault=1, 9 change_pulses, fault held until reset.
REQ-026 5 coins with coin+select id0 same cycle -> credit 3 after; coin during DISPENSE -> coin_rej, credit unchanged.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: FSM state encoding,
// default sizing parameters and the per-slot price table.
package vend_pkg;

  localparam int N_PROD       = 4;
  localparam int CREDIT_W     = 4;
  localparam int MAX_CREDIT   = 15;
  localparam int DISP_TIMEOUT = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPENSE,
    ST_CHANGE
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE [N_PROD] = '{4'd3, 4'd5, 4'd7, 4'd9};

endpackage

// File: rtl/vend_timeout_timer.sv
// Dispense watchdog: counts enabled cycles and flags the TIMEOUT-th one.
module vend_timeout_timer #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Expires on the TIMEOUT-th consecutive enabled cycle.
  assign o_expired = i_enable && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine sequencer: credit accounting, product select, dispense
// handshake with watchdog refund, and one-unit-per-cycle change return.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int N_PROD       = vend_pkg::N_PROD,
  parameter int CREDIT_W     = vend_pkg::CREDIT_W,
  parameter int MAX_CREDIT   = vend_pkg::MAX_CREDIT,
  parameter int DISP_TIMEOUT = vend_pkg::DISP_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin,
  input  logic                select,
  input  logic [1:0]          prod_id,
  input  logic                cancel,
  input  logic [N_PROD-1:0]   stock_empty,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic [1:0]          disp_id,
  output logic                change_pulse,
  output logic [CREDIT_W-1:0] credit,
  output logic                sel_err,
  output logic                coin_rej,
  output logic                busy,
  output logic                fault
);

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [CREDIT_W-1:0] w_sel_price, w_disp_price, w_credit_inc;
  logic [1:0]          r_disp_id, w_disp_id_nxt;
  logic                r_sel_err, w_sel_err_nxt;
  logic                r_coin_rej, w_coin_rej_nxt;
  logic                r_fault, w_fault_nxt;
  logic                w_coin_ok, w_expired, w_in_dispense;

  assign w_in_dispense = (r_state == ST_DISPENSE);
  assign w_sel_price   = CREDIT_W'(PRICE[prod_id]);
  assign w_disp_price  = CREDIT_W'(PRICE[r_disp_id]);
  // Coins are only banked in IDLE and never beyond the saturation value.
  assign w_coin_ok     = coin && (r_state == ST_IDLE) &&
                         (r_credit != CREDIT_W'(MAX_CREDIT));
  assign w_credit_inc  = r_credit + CREDIT_W'(w_coin_ok);

  vend_timeout_timer #(
    .TIMEOUT (DISP_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .i_clear   (!w_in_dispense),
    .i_enable  (w_in_dispense),
    .o_expired (w_expired)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_disp_id_nxt  = r_disp_id;
    w_sel_err_nxt  = 1'b0;
    w_coin_rej_nxt = coin && !w_coin_ok;
    w_fault_nxt    = r_fault;

    unique case (r_state)
      ST_IDLE: begin
        w_credit_nxt = w_credit_inc;
        if (cancel) begin
          if (r_credit != '0) w_state_nxt = ST_CHANGE;
        end else if (select) begin
          // Affordability is judged on the credit held before this cycle's coin.
          if (stock_empty[prod_id] || (r_credit < w_sel_price)) begin
            w_sel_err_nxt = 1'b1;
          end else begin
            w_credit_nxt  = w_credit_inc - w_sel_price;
            w_disp_id_nxt = prod_id;
            w_state_nxt   = ST_DISPENSE;
          end
        end
      end
      ST_DISPENSE: begin
        if (disp_ack) begin
          w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
        end else if (w_expired) begin
          w_credit_nxt = r_credit + w_disp_price;
          w_fault_nxt  = 1'b1;
          w_state_nxt  = ST_CHANGE;
        end
      end
      ST_CHANGE: begin
        w_credit_nxt = r_credit - CREDIT_W'(1);
        if (r_credit <= CREDIT_W'(1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_credit   <= '0;
      r_disp_id  <= '0;
      r_sel_err  <= 1'b0;
      r_coin_rej <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_disp_id  <= w_disp_id_nxt;
      r_sel_err  <= w_sel_err_nxt;
      r_coin_rej <= w_coin_rej_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  assign disp_req     = w_in_dispense;
  assign change_pulse = (r_state == ST_CHANGE);
  assign busy         = (r_state != ST_IDLE);
  assign disp_id      = r_disp_id;
  assign credit       = r_credit;
  assign sel_err      = r_sel_err;
  assign coin_rej     = r_coin_rej;
  assign fault        = r_fault;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed scenarios plus a randomized run of vend_sequencer, every cycle
// compared against a transaction-level credit/dispense/change model.
module tb_vend_sequencer;

  localparam int TIMEOUT = 32;
  localparam int MAXC    = 15;
  localparam int PRICE_T [4] = '{3, 5, 7, 9};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin = 1'b0, select = 1'b0, cancel = 1'b0, disp_ack = 1'b0;
  logic [1:0] prod_id = '0;
  logic [3:0] stock_empty = '0;
  logic       disp_req, change_pulse, sel_err, coin_rej, busy, fault;
  logic [1:0] disp_id;
  logic [3:0] credit;

  int total = 0;
  int bad   = 0;
  int n_pulses = 0;

  // Reference model: credit as an integer, a dispensing flag with elapsed
  // cycle count, and a refunding flag that drains credit one unit per cycle.
  int m_credit, m_disp_cnt, m_disp_id;
  bit m_disp, m_refunding, m_fault, e_sel_err, e_coin_rej;

  vend_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .coin         (coin),
    .select       (select),
    .prod_id      (prod_id),
    .cancel       (cancel),
    .stock_empty  (stock_empty),
    .disp_ack     (disp_ack),
    .disp_req     (disp_req),
    .disp_id      (disp_id),
    .change_pulse (change_pulse),
    .credit       (credit),
    .sel_err      (sel_err),
    .coin_rej     (coin_rej),
    .busy         (busy),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp))
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_disp_cnt = 0; m_disp_id = 0;
    m_disp = 0; m_refunding = 0; m_fault = 0;
    e_sel_err = 0; e_coin_rej = 0;
  endtask

  task automatic model_step(input bit c, input bit s, input int id, input bit x, input bit a);
    int pre;
    e_sel_err  = 0;
    e_coin_rej = 0;
    if (m_disp) begin
      e_coin_rej = c;
      m_disp_cnt++;
      if (a) begin
        m_disp      = 0;
        m_refunding = (m_credit > 0);
      end else if (m_disp_cnt == TIMEOUT) begin
        m_disp      = 0;
        m_credit   += PRICE_T[m_disp_id];
        m_fault     = 1;
        m_refunding = 1;
      end
    end else if (m_refunding) begin
      e_coin_rej = c;
      m_credit--;
      if (m_credit == 0) m_refunding = 0;
    end else begin
      pre = m_credit;
      if (x) begin
        if (pre > 0) m_refunding = 1;
      end else if (s) begin
        if (stock_empty[id] || pre < PRICE_T[id]) begin
          e_sel_err = 1;
        end else begin
          m_credit  -= PRICE_T[id];
          m_disp     = 1;
          m_disp_cnt = 0;
          m_disp_id  = id;
        end
      end
      if (c) begin
        if (pre == MAXC) e_coin_rej = 1;
        else m_credit++;
      end
    end
  endtask

  task automatic check_outputs();
    check("credit",       32'(credit),       m_credit);
    check("disp_req",     32'(disp_req),     int'(m_disp));
    check("disp_id",      32'(disp_id),      m_disp_id);
    check("change_pulse", 32'(change_pulse), int'(m_refunding));
    check("sel_err",      32'(sel_err),      int'(e_sel_err));
    check("coin_rej",     32'(coin_rej),     int'(e_coin_rej));
    check("busy",         32'(busy),         int'(m_disp || m_refunding));
    check("fault",        32'(fault),        int'(m_fault));
  endtask

  task automatic tick(input bit c, input bit s, input int id, input bit x, input bit a);
    coin = c; select = s; prod_id = id[1:0]; cancel = x; disp_ack = a;
    model_step(c, s, id, x, a);
    @(posedge clk);
    #1;
    coin = 0; select = 0; cancel = 0; disp_ack = 0;
    if (change_pulse === 1'b1) n_pulses++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic coins(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0);
  endtask

  // Asserts reset a few ns after a rising edge and checks outputs at once.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_busy",   32'(busy),   0);
    check("rst_credit", 32'(credit), 0);
    check_outputs();
    @(negedge clk);
    reset = 1'b1;
    n_pulses = 0;
  endtask

  initial begin
    model_reset();
    apply_reset();

    // Exact price, ack after a few cycles, no change owed.
    coins(3);
    check("s022_credit", 32'(credit), 3);
    tick(0, 1, 0, 0, 0);
    idle(3);
    tick(0, 0, 0, 0, 1);
    idle(2);
    check("s022_pulses", 32'(n_pulses), 0);

    // Overpay by two, expect two change pulses after ack.
    n_pulses = 0;
    coins(7);
    tick(0, 1, 1, 0, 0);
    idle(2);
    tick(0, 0, 0, 0, 1);
    idle(4);
    check("s023_pulses", 32'(n_pulses), 2);
    check("s023_busy",   32'(busy), 0);

    // Insufficient credit, cancel refund, then credit saturation.
    n_pulses = 0;
    coins(2);
    tick(0, 1, 1, 0, 0);
    check("s024_sel_err", 32'(sel_err), 1);
    tick(0, 0, 0, 1, 0);
    idle(4);
    check("s024_pulses", 32'(n_pulses), 2);
    coins(16);
    check("s024_sat",     32'(credit), 15);
    check("s024_coinrej", 32'(coin_rej), 1);
    tick(0, 0, 0, 1, 0);
    idle(16);

    // Empty slot rejects an otherwise affordable select.
    stock_empty = 4'b0100;
    coins(7);
    tick(0, 1, 2, 0, 0);
    tick(0, 0, 0, 1, 0);
    idle(8);
    stock_empty = 4'b0000;

    // Reset landing mid-change discards the remaining credit.
    coins(6);
    tick(0, 0, 0, 1, 0);
    idle(2);
    apply_reset();
    idle(2);

    // Dispense watchdog: refund of the full price, sticky fault.
    coins(9);
    tick(0, 1, 3, 0, 0);
    idle(45);
    check("s025_pulses", 32'(n_pulses), 9);
    check("s025_fault",  32'(fault), 1);
    idle(5);
    check("s025_held",   32'(fault), 1);
    apply_reset();

    // Coin and select together, then a coin rejected while dispensing.
    coins(5);
    tick(1, 1, 0, 0, 0);
    check("s026_credit", 32'(credit), 3);
    tick(1, 0, 0, 0, 0);
    check("s026_coinrej", 32'(coin_rej), 1);
    tick(0, 0, 0, 0, 1);
    idle(5);
    check("s026_pulses", 32'(n_pulses), 3);

    // Randomized traffic, with a reset thrown in halfway.
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) stock_empty = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if (i == 400) apply_reset();
      tick($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 20,
           int'($urandom_range(0, 3)), $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
